// File: rtl/dla_kpe_acc_if.sv
// dla_kpe_acc_if: product-in / psum-out handshake bundle for the KPE
// partial-sum accumulator.
//   in_vld/in_rdy/in_prod      : product stream into the accumulator
//   out_vld/out_rdy/out_psum   : completed partial sum toward the rounding stage
//   out_ovf                    : saturation flag for the group in out_psum
// master = the side that feeds products and drains sums; slave = accumulator.
interface dla_kpe_acc_if;
  logic        in_vld;
  logic        in_rdy;
  logic [31:0] in_prod;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out_psum;
  logic        out_ovf;

  modport master (
    output in_vld, in_prod, out_rdy,
    input  in_rdy, out_vld, out_psum, out_ovf
  );

  modport slave (
    input  in_vld, in_prod, out_rdy,
    output in_rdy, out_vld, out_psum, out_ovf
  );
endinterface

// File: rtl/dla_kpe_acc.sv
// dla_kpe_acc: KPE partial-sum accumulator.
// Sums (stgr_acc_len+1) signed products per output, either as one saturating
// 32-bit lane (PRECISION_IFMAP_16) or two independent saturating 16-bit lanes.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   stgr_precision_ifmap  : lane mode, latched at the first product of a group
//   stgr_acc_len          : products per output minus one, latched likewise
//   acc_if (slave)        : product input and registered psum output handshakes
package dla_kpe_acc_pkg;
  typedef enum logic {
    PRECISION_IFMAP_8  = 1'b0,
    PRECISION_IFMAP_16 = 1'b1
  } precision_ifmap_e;
endpackage

// Saturating signed adder of width W; one bit of headroom detects overflow.
module dla_kpe_acc_sat #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_clamp
);
  logic [W:0] w_s;
  assign w_s     = {i_a[W-1], i_a} + {i_b[W-1], i_b};
  // Overflow when the headroom bit disagrees with the result sign.
  assign o_clamp = w_s[W] ^ w_s[W-1];
  // Clamp toward the true sign carried by the headroom bit.
  assign o_sum   = o_clamp ? {w_s[W], {(W-1){~w_s[W]}}} : w_s[W-1:0];
endmodule

module dla_kpe_acc
  import dla_kpe_acc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  precision_ifmap_e   stgr_precision_ifmap,
  input  logic [7:0]         stgr_acc_len,
  dla_kpe_acc_if.slave       acc_if
);
  localparam int NUM_LANES = 2;
  localparam int LANE_W    = 16;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACC = 1'b1} state_e;

  state_e      r_state, w_state_nxt;
  logic        r_mode16;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic [31:0] r_acc;
  logic        r_sticky;
  logic        r_out_vld;
  logic [31:0] r_out_psum;
  logic        r_out_ovf;

  logic        w_mode16;
  logic [7:0]  w_len;
  logic [31:0] w_acc_base;
  logic        w_last_cand;
  logic        w_in_rdy;
  logic        w_xfer_in;
  logic        w_xfer_last;
  logic        w_xfer_out;

  logic [31:0] w_sum32;
  logic        w_clamp32;
  logic [NUM_LANES-1:0][LANE_W-1:0] w_acc_l;
  logic [NUM_LANES-1:0][LANE_W-1:0] w_prod_l;
  logic [NUM_LANES-1:0][LANE_W-1:0] w_sum_l;
  logic [NUM_LANES-1:0]             w_clamp_l;
  logic [31:0] w_sum;
  logic        w_clamp;

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_xfer_in && !w_last_cand) w_state_nxt = ST_ACC;
      ST_ACC:  if (w_xfer_last)               w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  // In IDLE the live config governs the product being offered, since that
  // product is the one that will latch it. The accumulator reads as zero
  // for the first product, so no clear cycle is needed between groups.
  always_comb begin
    w_mode16   = (stgr_precision_ifmap == PRECISION_IFMAP_16);
    w_len      = stgr_acc_len;
    w_acc_base = '0;
    if (r_state == ST_ACC) begin
      w_mode16   = r_mode16;
      w_len      = r_len;
      w_acc_base = r_acc;
    end
    // r_cnt is zero in IDLE, so this also covers the length-1 group case.
    w_last_cand = (r_cnt == w_len);
    // Only a last product needs the output register; it waits while that
    // register holds an undrained sum.
    w_in_rdy    = !(w_last_cand && r_out_vld && !acc_if.out_rdy);
  end

  assign w_xfer_in   = acc_if.in_vld && w_in_rdy;
  assign w_xfer_last = w_xfer_in && w_last_cand;
  assign w_xfer_out  = r_out_vld && acc_if.out_rdy;

  // ---- datapath: one 32-bit lane and two independent 16-bit lanes ----
  dla_kpe_acc_sat #(.W(32)) u_sat32 (
    .i_a     (w_acc_base),
    .i_b     (acc_if.in_prod),
    .o_sum   (w_sum32),
    .o_clamp (w_clamp32)
  );

  assign w_acc_l  = w_acc_base;
  assign w_prod_l = acc_if.in_prod;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dla_kpe_acc_sat #(.W(LANE_W)) u_sat16 (
      .i_a     (w_acc_l[g]),
      .i_b     (w_prod_l[g]),
      .o_sum   (w_sum_l[g]),
      .o_clamp (w_clamp_l[g])
    );
  end

  assign w_sum   = w_mode16 ? w_sum32   : w_sum_l;
  assign w_clamp = w_mode16 ? w_clamp32 : |w_clamp_l;

  // ---- group and output registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode16   <= 1'b0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_sticky   <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_psum <= '0;
      r_out_ovf  <= 1'b0;
    end else begin
      if (w_xfer_in && r_state == ST_IDLE) begin
        r_mode16 <= (stgr_precision_ifmap == PRECISION_IFMAP_16);
        r_len    <= stgr_acc_len;
      end
      if (w_xfer_in) begin
        if (w_last_cand) begin
          r_out_psum <= w_sum;
          r_out_ovf  <= r_sticky | w_clamp;
          r_cnt      <= '0;
          r_sticky   <= 1'b0;
        end else begin
          r_acc    <= w_sum;
          r_cnt    <= r_cnt + 8'd1;
          r_sticky <= r_sticky | w_clamp;
        end
      end
      // A new sum landing in the drain cycle keeps out_vld high (no bubble).
      if (w_xfer_last)     r_out_vld <= 1'b1;
      else if (w_xfer_out) r_out_vld <= 1'b0;
    end
  end

  assign acc_if.in_rdy   = w_in_rdy;
  assign acc_if.out_vld  = r_out_vld;
  assign acc_if.out_psum = r_out_psum;
  assign acc_if.out_ovf  = r_out_ovf;
endmodule
